// File: rtl/wave_capture_if.sv
// wave_capture_if: sample stream, display-idle and waveform-RAM write port
// for the wave_capture block.
//
// Handshake: new_sample_ready is a one-cycle strobe that qualifies
// new_sample_in in the same cycle. There is no ready/backpressure: every
// strobe is accepted. Strobes may arrive on consecutive cycles.
// write_enable is a one-cycle strobe that qualifies write_address and
// write_sample in the same cycle.
// state_dbg exposes the capture FSM state (0 ARMED, 1 ACTIVE, 2 WAIT).
interface wave_capture_if #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 9
);
  logic                       new_sample_ready;
  logic signed [SAMPLE_W-1:0] new_sample_in;
  logic                       wave_display_idle;
  logic [ADDR_W-1:0]          write_address;
  logic                       write_enable;
  logic [7:0]                 write_sample;
  logic                       read_index;
  logic [1:0]                 state_dbg;

  // Capture block side.
  modport slave (
    input  new_sample_ready,
    input  new_sample_in,
    input  wave_display_idle,
    output write_address,
    output write_enable,
    output write_sample,
    output read_index,
    output state_dbg
  );

  // Environment side: sample source, display and RAM.
  modport master (
    output new_sample_ready,
    output new_sample_in,
    output wave_display_idle,
    input  write_address,
    input  write_enable,
    input  write_sample,
    input  read_index,
    input  state_dbg
  );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: writer side of a double-buffered 512x8 waveform RAM.
// Arms on a rising zero crossing of the audio stream, stores NUM_SAMPLES
// consecutive samples into the half the display is not reading, then
// swaps halves while the display is idle.
// Optional macro WAVE_CAPTURE_AUTOTRIG_EN: forces a trigger after
// AUTO_TRIG_SAMPLES strobes in ARMED so silent/DC input still refreshes.
module wave_capture #(
  parameter int SAMPLE_W          = 16,
  parameter int NUM_SAMPLES       = 256,
  parameter int AUTO_TRIG_SAMPLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  wave_capture_if.slave  cap_if
);

  localparam int CNT_W  = $clog2(NUM_SAMPLES);
  localparam int ADDR_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  // Holdoff counter is at least 11 bits wide so the default 1024 fits.
  localparam int HOLD_W_RAW = $clog2(AUTO_TRIG_SAMPLES + 1);
  localparam int HOLD_W     = (HOLD_W_RAW > 11) ? HOLD_W_RAW : 11;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(AUTO_TRIG_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                prev_msb_q, prev_msb_d;
  logic                read_index_q, read_index_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;

  logic                sample_msb;
  logic [7:0]          sample_fmt;
  logic                zero_cross;
  logic                auto_trig;

  // Offset-binary conversion of the top 8 bits: flip the sign bit.
  assign sample_msb = cap_if.new_sample_in[SAMPLE_W-1];
  assign sample_fmt = {~sample_msb, cap_if.new_sample_in[SAMPLE_W-2 -: 7]};
  // Negative-to-non-negative transition between consecutive strobes.
  assign zero_cross = cap_if.new_sample_ready & prev_msb_q & ~sample_msb;

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  logic [HOLD_W-1:0] holdoff_q, holdoff_d;

  // The AUTO_TRIG_SAMPLES-th strobe seen in ARMED fires a trigger.
  assign auto_trig = cap_if.new_sample_ready && (holdoff_q == HOLD_LAST);

  // Holdoff counts strobes only while ARMED; it is zero on every entry.
  always_comb begin
    holdoff_d = holdoff_q;
    if (state_q != ST_ARMED) begin
      holdoff_d = '0;
    end else if (cap_if.new_sample_ready && !zero_cross && !auto_trig) begin
      holdoff_d = holdoff_q + 1'b1;
    end else if (zero_cross || auto_trig) begin
      holdoff_d = '0;
    end
  end

  // Holdoff counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      holdoff_q <= '0;
    end else begin
      holdoff_q <= holdoff_d;
    end
  end
`else
  logic unused_autotrig_cfg;
  assign unused_autotrig_cfg = ^HOLD_LAST;
  assign auto_trig = 1'b0;
`endif

  // Next-state and registered-output logic for the capture FSM.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    prev_msb_d   = prev_msb_q;
    read_index_d = read_index_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;

    // Sign history tracks every strobe regardless of state.
    if (cap_if.new_sample_ready) begin
      prev_msb_d = sample_msb;
    end

    case (state_q)
      ST_ARMED: begin
        // The triggering sample is the first stored sample.
        if (zero_cross || auto_trig) begin
          we_d    = 1'b1;
          addr_d  = {~read_index_q, {CNT_W{1'b0}}};
          data_d  = sample_fmt;
          count_d = CNT_W'(1);
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cap_if.new_sample_ready) begin
          we_d   = 1'b1;
          addr_d = {~read_index_q, count_q};
          data_d = sample_fmt;
          if (count_q == LAST_CNT) begin
            count_d = '0;
            state_d = ST_WAIT;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Swap halves only while the display is not drawing.
        if (cap_if.wave_display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_ARMED;
        count_d = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any partial capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_ARMED;
      count_q      <= '0;
      prev_msb_q   <= 1'b0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      prev_msb_q   <= prev_msb_d;
      read_index_q <= read_index_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign cap_if.write_enable  = we_q;
  assign cap_if.write_address = addr_q;
  assign cap_if.write_sample  = data_q;
  assign cap_if.read_index    = read_index_q;
  assign cap_if.state_dbg     = state_q;

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed bench for wave_capture. Inputs change 1 ns
// after the falling edge; outputs are observed there as well.
module tb_wave_capture;

  localparam logic [1:0] S_ARMED  = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  // Clock / reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_capture_if #(.SAMPLE_W(16), .ADDR_W(9)) bus ();

  wave_capture #(
    .SAMPLE_W         (16),
    .NUM_SAMPLES      (256),
    .AUTO_TRIG_SAMPLES(1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cap_if(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: observed writes {addr, data} and expected writes.
  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  int run_len = 0;
  int max_run = 0;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      obs_q.push_back({bus.write_address, bus.write_sample});
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] obs_at(input int idx);
    if (idx < obs_q.size()) return obs_q[idx];
    return 17'h1FFFF;
  endfunction

  // One strobe followed by three quiet cycles.
  task automatic strobe(input logic [15:0] s);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = s;
    cycle();
    bus.new_sample_ready = 1'b0;
    repeat (3) cycle();
  endtask

  // Compare writes recorded since base against exp_q, then clear exp_q.
  task automatic check_writes(input string tag, input int base);
    check({tag, "_count"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, obs_at(base + i), exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic pulse_idle();
    bus.wave_display_idle = 1'b1;
    cycle();
    bus.wave_display_idle = 1'b0;
  endtask

  initial begin
    int base;
    int first_wr_at;
    logic [8:0] a;
    logic [7:0] d;
    logic [15:0] smp;

    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;
    reset = 1'b0;

    // Reset held with strobes present: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      bus.new_sample_ready = 1'b1;
      bus.new_sample_in    = (i == 0) ? 16'hF000 : 16'h0100;
      cycle();
      check("rst_outputs", {bus.write_enable, bus.read_index, bus.write_address, bus.write_sample}, 32'h0);
      check("rst_state", bus.state_dbg, S_ARMED);
    end
    bus.new_sample_ready = 1'b0;
    reset = 1'b1;
    cycle();

    // Trigger and fill into the upper half.
    base = obs_q.size();
    strobe(16'hF000);
    check("f000_no_write", obs_q.size() - base, 0);
    for (int i = 1; i <= 256; i++) begin
      smp = 16'(i << 8);
      strobe(smp);
      a = 9'(9'h100 + i - 1);
      d = 8'(i) ^ 8'h80;
      exp_q.push_back({a, d});
    end
    check("fill_first", obs_at(base), {9'h100, 8'h81});
    check("fill_second", obs_at(base + 1), {9'h101, 8'h82});
    check("fill_last_addr", obs_at(base + 255) >> 8, 9'h1FF);
    check_writes("fill", base);
    strobe(16'h0000);
    check("fill_257_ignored", obs_q.size() - base, 256);
    check("fill_state_wait", bus.state_dbg, S_WAIT);

    // Buffer swap only when the display goes idle.
    repeat (50) cycle();
    check("swap_hold_ri", bus.read_index, 1'b0);
    check("swap_hold_state", bus.state_dbg, S_WAIT);
    bus.wave_display_idle = 1'b1;
    check("swap_pulse_ri", bus.read_index, 1'b0);
    cycle();
    bus.wave_display_idle = 1'b0;
    check("swap_after_ri", bus.read_index, 1'b1);
    check("swap_after_state", bus.state_dbg, S_ARMED);
    pulse_idle();
    cycle();
    check("idle_in_armed", bus.read_index, 1'b1);

    // Partial capture into the lower half, then reset mid-capture.
    base = obs_q.size();
    strobe(16'h9000);
    for (int k = 1; k <= 100; k++) begin
      smp = 16'(k << 8);
      strobe(smp);
      a = 9'(k - 1);
      d = 8'(k) ^ 8'h80;
      exp_q.push_back({a, d});
    end
    check_writes("mid", base);
    check("mid_state", bus.state_dbg, S_ACTIVE);
    reset = 1'b0;
    cycle();
    check("mid_rst_outputs", {bus.write_enable, bus.read_index, bus.write_address, bus.write_sample}, 32'h0);
    check("mid_rst_state", bus.state_dbg, S_ARMED);
    reset = 1'b1;
    cycle();

    // After reset a non-negative sample cannot trigger.
    base = obs_q.size();
    strobe(16'h0100);
    check("post_rst_no_trig", obs_q.size() - base, 0);
    check("post_rst_state", bus.state_dbg, S_ARMED);

    // Back-to-back strobes: 256 consecutive writes into the upper half.
    max_run = 0;
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = 16'h9000;
    cycle();
    for (int k = 0; k <= 256; k++) begin
      bus.new_sample_in = 16'(k << 8);
      cycle();
      if (k < 256) begin
        a = 9'(9'h100 + k);
        d = 8'(k) ^ 8'h80;
        exp_q.push_back({a, d});
      end
    end
    bus.new_sample_ready = 1'b0;
    cycle();
    check_writes("b2b", base);
    check("b2b_run", max_run, 256);
    check("b2b_state", bus.state_dbg, S_WAIT);
    check("b2b_ri", bus.read_index, 1'b0);
    pulse_idle();
    check("b2b_swap_ri", bus.read_index, 1'b1);

    // DC input: no zero crossing.
    base = obs_q.size();
    first_wr_at = 0;
    bus.new_sample_ready = 1'b1;
    for (int j = 1; j <= 4000; j++) begin
      bus.new_sample_in = (j <= 2000) ? 16'h1000 : 16'h9000;
      cycle();
      if (first_wr_at == 0 && obs_q.size() > base) first_wr_at = j;
    end
    bus.new_sample_ready = 1'b0;
    cycle();
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    check("auto_first_at", first_wr_at, 1024);
    for (int k = 0; k < 256; k++) begin
      a = 9'(k);
      exp_q.push_back({a, 8'h90});
    end
    check_writes("auto", base);
    check("auto_state", bus.state_dbg, S_WAIT);
`else
    check("dc_writes", obs_q.size() - base, 0);
    check("dc_first_at", first_wr_at, 0);
    check("dc_state", bus.state_dbg, S_ARMED);
    check("dc_ri", bus.read_index, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Writer side of the double-buffered waveform RAM (512 x 8) that the waveform display reads.
- Watches the incoming audio sample stream and arms on a rising zero crossing.
- Writes 256 consecutive samples into the half of the RAM the display is not reading.
- Flips read_index while the display is idle, so the new capture is shown without tearing.

Parameters:
- SAMPLE_W, 16, width of the signed two's-complement audio input sample.
- NUM_SAMPLES, 256, samples per capture; equals the RAM half depth, must be a power of two.
- AUTO_TRIG_SAMPLES, 1024, sample count before a forced trigger (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  SAMPLE_W  signed audio sample.
- wave_display_idle  input  1  high while the display is outside its drawing window; safe to swap buffers.
- write_address  output  9  RAM write address {~read_index, sample_count[7:0]}.
- write_enable  output  1  RAM write strobe, one cycle per stored sample.
- write_sample  output  8  offset-binary sample: {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]}.
- read_index  output  1  RAM half the display reads; the capture always writes the other half.

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - state=ARMED, sample_count=0, prev_msb=0, read_index=0;
  - write_enable=0, write_address=0, write_sample=0.
- Reset mid-capture abandons the partial capture; read_index returns to 0.
- All outputs are registered. A write occurs exactly 1 cycle after the accepted new_sample_ready strobe.
- prev_msb <= new_sample_in[MSB] on every new_sample_ready, in every state.
- Trigger condition: new_sample_ready & prev_msb==1 & new_sample_in[MSB]==0 (negative to non-negative).
- State ARMED:
  - No writes.
  - On trigger -> ACTIVE. The triggering sample is itself written at sample_count 0, and sample_count becomes 1.
- State ACTIVE:
  - Each new_sample_ready: write_enable=1 next cycle, write_address={~read_index, sample_count}, write_sample formatted as above; then sample_count++.
  - After the write at sample_count==NUM_SAMPLES-1, sample_count wraps to 0 and state -> WAIT.
  - Zero crossings in ACTIVE are ignored.
- State WAIT:
  - No writes; new_sample_ready is ignored except for the prev_msb update.
  - On the first cycle wave_display_idle==1: read_index toggles (registered) and state -> ARMED.
  - If wave_display_idle is already high on the cycle WAIT is entered, the flip happens on the next cycle.
- wave_display_idle has no effect in ARMED or ACTIVE.
- write_enable is never high for two consecutive cycles unless new_sample_ready strobes on consecutive cycles; back-to-back strobes must be supported.
- write_address MSB is always ~read_index as it stood at write time; read_index never changes during ACTIVE.
- The first trigger after reset needs a negative sample first: prev_msb resets to 0, so an initial non-negative sample cannot trigger.

Optional Feature:
- Macro: WAVE_CAPTURE_AUTOTRIG_EN.
- Defined:
  - An 11-bit-or-wider holdoff counter counts new_sample_ready strobes while in ARMED, and clears on entry to ARMED.
  - When it reaches AUTO_TRIG_SAMPLES, that strobe is treated as a trigger regardless of sign, giving a free-running display for DC or silent input.
- Undefined: no counter; ARMED waits indefinitely for a real zero crossing.

Test Plan:
- Reset: hold reset=0 for 3 cycles with strobes present -> write_enable=0, read_index=0, write_address=0, write_sample=0 throughout.
- Trigger and fill:
  - Stimulus: strobe sample 16'hF000, then a ramp 16'h0100, 16'h0200, ... (256 strobes, 4 clk apart).
  - Required: first write is addr 9'h100, data 8'h81; then addr 9'h101, data 8'h82; last write at addr 9'h1FF; no write on the 257th strobe.
- Buffer swap:
  - Stimulus: after the fill, hold wave_display_idle=0 for 50 cycles, then pulse it 1 for one cycle.
  - Required: read_index changes 0->1 exactly one cycle after the pulse; the next capture writes at 9'h000..9'h0FF.
- No false trigger:
  - Stimulus: 2000 strobes of constant 16'h1000, then 2000 of 16'h9000.
  - Required with macro undefined: zero writes.
  - Required with WAVE_CAPTURE_AUTOTRIG_EN and AUTO_TRIG_SAMPLES=1024: capture starts on the 1024th strobe.
- Back-to-back strobes: new_sample_ready held high 256 cycles after a trigger -> 256 consecutive write_enable cycles, addresses incrementing by 1.
- Reset mid-capture: assert reset after 100 writes with read_index=1 -> read_index=0, state ARMED; the next trigger writes at address 9'h100.
